// File: rtl/tile_scheduler_if.sv
// Handshake bundle between the tile scheduler and its host, input and drain controllers.
// Index widths are derived here from the tile geometry, so both ends agree on them.
interface tile_scheduler_if #(
    parameter int ADDR_WIDTH   = 23,
    parameter int MAC_SIZE     = 32,
    parameter int BIG_MAC_SIZE = 512
);
    localparam int DIVIDE = BIG_MAC_SIZE / MAC_SIZE;
    localparam int IDX_W  = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;

    logic                  start;
    logic                  abort;
    logic                  tile_done;
    logic                  drain_ready;
    logic                  comp_enb;
    logic [ADDR_WIDTH-1:0] base_addr_A;
    logic [ADDR_WIDTH-1:0] base_addr_B;
    logic [IDX_W-1:0]      row_idx;
    logic [IDX_W-1:0]      col_idx;
    logic [2*IDX_W:0]      tile_count;
    logic                  drain_req;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        input  start, abort, tile_done, drain_ready,
        output comp_enb, base_addr_A, base_addr_B, row_idx, col_idx,
               tile_count, drain_req, busy, done, err
    );

    modport slave (
        output start, abort, tile_done, drain_ready,
        input  comp_enb, base_addr_A, base_addr_B, row_idx, col_idx,
               tile_count, drain_req, busy, done, err
    );
endinterface

// File: rtl/tile_scheduler.sv
// Walks a DIVIDE x DIVIDE grid of MAC tiles: arm, run, drain per tile, then signal done.
// Optional RUN watchdog is enabled by defining TILE_SCHED_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for start, input controller held (comp_enb=1)
// ARM    | comp_enb held high for ARM_CYCLES cycles
// RUN    | comp_enb low, waiting for tile_done
// DRAIN  | drain_req high until drain_ready, then advance indices
// FINISH | one-cycle done pulse, back to IDLE
module tile_scheduler #(
    parameter int ADDR_WIDTH     = 23,
    parameter int MAC_SIZE       = 32,
    parameter int BIG_MAC_SIZE   = 512,
    parameter int B_ADDR_HEAD    = 15,
    parameter int ARM_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic              clk,
    input  logic              rst,
    tile_scheduler_if.master  bus
);
    localparam int DIVIDE     = BIG_MAC_SIZE / MAC_SIZE;
    localparam int IDX_W      = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
    localparam int CNT_W      = 2 * IDX_W + 1;
    localparam int HEAD_SHIFT = B_ADDR_HEAD - IDX_W;
    localparam int ARM_W      = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
    localparam logic [ARM_W-1:0] ARM_LOAD = ARM_W'(ARM_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIVIDE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t           state, state_nxt;
    logic [ARM_W-1:0] arm_cnt, arm_nxt;
    logic [IDX_W-1:0] row, row_nxt, col, col_nxt;
    logic [CNT_W-1:0] tile_count, cnt_nxt;
    logic             err, err_nxt;
    logic             comp_enb_c, drain_req_c, done_c;
    logic             force_idle;
`ifdef TILE_SCHED_TIMEOUT_EN
    logic [16:0]      wdog;
    logic             timeout;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            arm_cnt    <= '0;
            row        <= '0;
            col        <= '0;
            tile_count <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            arm_cnt    <= arm_nxt;
            row        <= row_nxt;
            col        <= col_nxt;
            tile_count <= cnt_nxt;
            err        <= err_nxt;
        end
    end

`ifdef TILE_SCHED_TIMEOUT_EN
    // Counts cycles spent in RUN; zero on every RUN entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                wdog <= '0;
        else if (state == S_RUN) wdog <= wdog + 17'd1;
        else                    wdog <= '0;
    end

    assign timeout = (state == S_RUN) && !bus.tile_done &&
                     (wdog == 17'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_nxt   = state;
        arm_nxt     = arm_cnt;
        row_nxt     = row;
        col_nxt     = col;
        cnt_nxt     = tile_count;
        err_nxt     = err;
        comp_enb_c  = 1'b1;
        drain_req_c = 1'b0;
        done_c      = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_nxt = S_ARM;
                    arm_nxt   = ARM_LOAD;
                    row_nxt   = '0;
                    col_nxt   = '0;
                    cnt_nxt   = '0;
                    err_nxt   = 1'b0;
                end
            end
            S_ARM: begin
                if (arm_cnt == '0) state_nxt = S_RUN;
                else               arm_nxt   = arm_cnt - 1'b1;
            end
            S_RUN: begin
                comp_enb_c = 1'b0;
                if (bus.tile_done) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                drain_req_c = 1'b1;
                if (bus.drain_ready) begin
                    cnt_nxt = tile_count + CNT_W'(1);
                    if (col == IDX_LAST) begin
                        col_nxt = '0;
                        row_nxt = (row == IDX_LAST) ? '0 : row + 1'b1;
                    end else begin
                        col_nxt = col + 1'b1;
                    end
                    if (row == IDX_LAST && col == IDX_LAST) begin
                        state_nxt = S_FINISH;
                    end else begin
                        state_nxt = S_ARM;
                        arm_nxt   = ARM_LOAD;
                    end
                end
            end
            S_FINISH: begin
                done_c    = 1'b1;
                row_nxt   = '0;
                col_nxt   = '0;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        if (bus.tile_done && state != S_RUN) err_nxt = 1'b1;

        force_idle = bus.abort && (state != S_IDLE);
`ifdef TILE_SCHED_TIMEOUT_EN
        if (timeout) err_nxt = 1'b1;
        force_idle = force_idle || timeout;
`endif
        // Abort wins over any same-cycle progress; indices keep their last values.
        if (force_idle) begin
            state_nxt = S_IDLE;
            arm_nxt   = arm_cnt;
            row_nxt   = row;
            col_nxt   = col;
            cnt_nxt   = tile_count;
        end
    end

    assign bus.comp_enb    = comp_enb_c;
    assign bus.drain_req   = drain_req_c;
    assign bus.done        = done_c;
    assign bus.busy        = (state != S_IDLE);
    assign bus.err         = err;
    assign bus.row_idx     = row;
    assign bus.col_idx     = col;
    assign bus.tile_count  = tile_count;
    assign bus.base_addr_A = ADDR_WIDTH'(row) << HEAD_SHIFT;
    assign bus.base_addr_B = (ADDR_WIDTH'(col) << HEAD_SHIFT) + (ADDR_WIDTH'(1) << B_ADDR_HEAD);
endmodule

// File: tb/tb_tile_scheduler.sv
// Directed bench for tile_scheduler on a 2x2 tile grid (MAC_SIZE=4, BIG_MAC_SIZE=8).
// The watchdog scenario is compiled in only when TILE_SCHED_TIMEOUT_EN is defined.
module tb_tile_scheduler;
    localparam int ADDR_WIDTH = 23;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   done_cnt = 0;
    int   d0;

    int exp_row [4] = '{0, 0, 1, 1};
    int exp_col [4] = '{0, 1, 0, 1};
    int exp_a   [4] = '{32'h0000, 32'h0000, 32'h4000, 32'h4000};
    int exp_b   [4] = '{32'h8000, 32'hC000, 32'h8000, 32'hC000};

    always #5 clk = ~clk;

    tile_scheduler_if #(.ADDR_WIDTH(ADDR_WIDTH), .MAC_SIZE(4), .BIG_MAC_SIZE(8)) bus ();

    tile_scheduler #(
        .ADDR_WIDTH(ADDR_WIDTH), .MAC_SIZE(4), .BIG_MAC_SIZE(8),
        .B_ADDR_HEAD(15), .ARM_CYCLES(2), .TIMEOUT_CYCLES(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_run(input int budget);
        int n = 0;
        while (bus.comp_enb !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        check("reach_run", 32'(bus.comp_enb), 32'd0);
    endtask

    task automatic finish_tile;
        repeat (4) tick();
        bus.tile_done = 1'b1;
        tick();
        bus.tile_done = 1'b0;
    endtask

    task automatic check_reset(input string p);
        check({p, "_comp_enb"},  32'(bus.comp_enb),  32'd1);
        check({p, "_busy"},      32'(bus.busy),      32'd0);
        check({p, "_done"},      32'(bus.done),      32'd0);
        check({p, "_err"},       32'(bus.err),       32'd0);
        check({p, "_drain_req"}, 32'(bus.drain_req), 32'd0);
        check({p, "_row"},       32'(bus.row_idx),   32'd0);
        check({p, "_col"},       32'(bus.col_idx),   32'd0);
        check({p, "_count"},     32'(bus.tile_count), 32'd0);
        check({p, "_addr_a"},    32'(bus.base_addr_A), 32'h0000);
        check({p, "_addr_b"},    32'(bus.base_addr_B), 32'h8000);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.tile_done = 1'b0; bus.drain_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst");
        rst = 1'b0;
        tick();

        // Full job with arm timing on the first tile.
        bus.drain_ready = 1'b1;
        d0 = done_cnt;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("arm_t1", 32'(bus.comp_enb), 32'd1);
        check("arm_busy", 32'(bus.busy), 32'd1);
        tick();
        check("arm_t2", 32'(bus.comp_enb), 32'd1);
        tick();
        check("arm_t3", 32'(bus.comp_enb), 32'd0);
        for (int k = 0; k < 4; k++) begin
            wait_run(10);
            check("job_row",    32'(bus.row_idx),     32'(exp_row[k]));
            check("job_col",    32'(bus.col_idx),     32'(exp_col[k]));
            check("job_addr_a", 32'(bus.base_addr_A), 32'(exp_a[k]));
            check("job_addr_b", 32'(bus.base_addr_B), 32'(exp_b[k]));
            finish_tile();
            check("job_drain_req", 32'(bus.drain_req),  32'd1);
            check("job_drain_enb", 32'(bus.comp_enb),   32'd1);
            check("job_count",     32'(bus.tile_count), 32'(k));
            tick();
        end
        check("job_done",       32'(bus.done),       32'd1);
        check("job_done_count", 32'(bus.tile_count), 32'd4);
        check("job_done_busy",  32'(bus.busy),       32'd1);
        tick();
        check("job_idle_busy", 32'(bus.busy), 32'd0);
        check("job_idle_done", 32'(bus.done), 32'd0);
        check("job_done_once", 32'(done_cnt - d0), 32'd1);

        // Drain backpressure on the first tile.
        bus.drain_ready = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_run(10);
        finish_tile();
        for (int i = 0; i < 10; i++) begin
            check("bp_drain_req", 32'(bus.drain_req),  32'd1);
            check("bp_col_hold",  32'(bus.col_idx),    32'd0);
            check("bp_cnt_hold",  32'(bus.tile_count), 32'd0);
            tick();
        end
        bus.drain_ready = 1'b1;
        tick();
        bus.drain_ready = 1'b0;
        check("bp_release_req", 32'(bus.drain_req),  32'd0);
        check("bp_advance_col", 32'(bus.col_idx),    32'd1);
        check("bp_advance_cnt", 32'(bus.tile_count), 32'd1);

        // Abort while running tile (0,1), with a same-cycle tile_done.
        wait_run(10);
        check("ab_col", 32'(bus.col_idx), 32'd1);
        check("ab_row", 32'(bus.row_idx), 32'd0);
        tick();
        tick();
        d0 = done_cnt;
        bus.abort = 1'b1;
        bus.tile_done = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.tile_done = 1'b0;
        check("ab_busy",      32'(bus.busy),       32'd0);
        check("ab_comp_enb",  32'(bus.comp_enb),   32'd1);
        check("ab_drain_req", 32'(bus.drain_req),  32'd0);
        check("ab_col_hold",  32'(bus.col_idx),    32'd1);
        check("ab_cnt_hold",  32'(bus.tile_count), 32'd1);
        check("ab_err",       32'(bus.err),        32'd0);
        tick();
        tick();
        check("ab_no_done", 32'(done_cnt - d0), 32'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("restart_row",   32'(bus.row_idx),    32'd0);
        check("restart_col",   32'(bus.col_idx),    32'd0);
        check("restart_count", 32'(bus.tile_count), 32'd0);
        check("restart_busy",  32'(bus.busy),       32'd1);

        // start during RUN is ignored.
        wait_run(10);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("run_start_state", 32'(bus.comp_enb),   32'd0);
        check("run_start_err",   32'(bus.err),        32'd0);
        check("run_start_count", 32'(bus.tile_count), 32'd0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("run_abort_busy", 32'(bus.busy), 32'd0);

        // Spurious tile_done in IDLE, then start+abort, then a clean start clears err.
        bus.tile_done = 1'b1;
        tick();
        bus.tile_done = 1'b0;
        check("spur_err",  32'(bus.err),  32'd1);
        check("spur_busy", 32'(bus.busy), 32'd0);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("sa_busy", 32'(bus.busy), 32'd0);
        check("sa_err",  32'(bus.err),  32'd1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("clr_err",  32'(bus.err),  32'd0);
        check("clr_busy", 32'(bus.busy), 32'd1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;

        // Asynchronous reset in the middle of DRAIN.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_run(10);
        finish_tile();
        check("pre_rst_drain", 32'(bus.drain_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset("arst");
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_busy", 32'(bus.busy), 32'd0);

`ifdef TILE_SCHED_TIMEOUT_EN
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_run(10);
        repeat (19) tick();
        check("wd_still_run", 32'(bus.comp_enb), 32'd0);
        check("wd_no_err",    32'(bus.err),      32'd0);
        tick();
        check("wd_busy",     32'(bus.busy),     32'd0);
        check("wd_err",      32'(bus.err),      32'd1);
        check("wd_comp_enb", 32'(bus.comp_enb), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
